// File: rtl/pipe_mux_tree_if.sv
// Beat interface of the pipelined select tree: capture-side handshake, data and
// select in, selected word with its sel/tag out.
interface pipe_mux_tree_if #(
   parameter int NUM_INPUTS = 16,
   parameter int DATA_WIDTH = 16,
   parameter int TAG_WIDTH  = 4
);
   localparam int SEL_WIDTH = $clog2(NUM_INPUTS);

   logic                             valid_i;
   logic                             ready_o;
   logic [SEL_WIDTH-1:0]             sel;
   logic [TAG_WIDTH-1:0]             tag_i;
   logic [NUM_INPUTS*DATA_WIDTH-1:0] input_word;
   logic                             valid_o;
   logic                             ready_i;
   logic [SEL_WIDTH-1:0]             sel_o;
   logic [TAG_WIDTH-1:0]             tag_o;
   logic [DATA_WIDTH-1:0]            output_word;

   modport master (
      output valid_i, sel, tag_i, input_word, ready_i,
      input  ready_o, valid_o, sel_o, tag_o, output_word
   );

   modport slave (
      input  valid_i, sel, tag_i, input_word, ready_i,
      output ready_o, valid_o, sel_o, tag_o, output_word
   );
endinterface

// File: rtl/pipe_mux_tree.sv
// Pipelined N:1 word select: input capture stage followed by one registered
// radix-RADIX mux level per sel digit, with valid/ready and bubble collapse.
module pipe_mux_tree #(
   parameter int NUM_INPUTS = 16,
   parameter int DATA_WIDTH = 16,
   parameter int RADIX      = 4,
   parameter int TAG_WIDTH  = 4
) (
   input logic            clk,
   input logic            async_reset_n,
   pipe_mux_tree_if.slave bus
);
   localparam int SEL_WIDTH = $clog2(NUM_INPUTS);
   localparam int DIGIT_W   = $clog2(RADIX);
   localparam int LEVELS    = (SEL_WIDTH + DIGIT_W - 1) / DIGIT_W;

   logic [LEVELS:0]      vld_q;
   logic [LEVELS:0]      load;
   logic [SEL_WIDTH-1:0] sel_q [0:LEVELS];
   logic [TAG_WIDTH-1:0] tag_q [0:LEVELS];

   // A stage may load when empty or when its successor loads; the chain is
   // built from ready_i backwards so valid_i never reaches ready_o.
   always_comb begin : load_chain
      logic chain;
      load         = '0;
      chain        = !vld_q[LEVELS] || bus.ready_i;
      load[LEVELS] = chain;
      for (int k = LEVELS - 1; k >= 0; k--) begin
         chain   = !vld_q[k] || chain;
         load[k] = chain;
      end
   end

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         vld_q <= '0;
         for (int k = 0; k <= LEVELS; k++) begin
            sel_q[k] <= '0;
            tag_q[k] <= '0;
         end
      end else begin
         if (load[0]) begin
            vld_q[0] <= bus.valid_i;
            if (bus.valid_i) begin
               sel_q[0] <= bus.sel;
               tag_q[0] <= bus.tag_i;
            end
         end
         for (int k = 1; k <= LEVELS; k++) begin
            if (load[k]) begin
               vld_q[k] <= vld_q[k-1];
               if (vld_q[k-1]) begin
                  sel_q[k] <= sel_q[k-1];
                  tag_q[k] <= tag_q[k-1];
               end
            end
         end
      end
   end

   // Stage j holds RADIX**(LEVELS-j) words; stage 0 zero-pads the inputs.
   genvar j;
   generate
      for (j = 0; j <= LEVELS; j++) begin : g_st
         localparam int WORDS = RADIX ** (LEVELS - j);
         logic [WORDS*DATA_WIDTH-1:0] data_q;
         logic [WORDS*DATA_WIDTH-1:0] data_d;
         logic                        pred_vld;

         if (j == 0) begin : g_cap
            assign data_d   = (WORDS*DATA_WIDTH)'(bus.input_word);
            assign pred_vld = bus.valid_i;
         end else begin : g_tree
            logic [DIGIT_W-1:0] digit;
            assign digit    = DIGIT_W'(sel_q[j-1] >> ((j - 1) * DIGIT_W));
            assign pred_vld = vld_q[j-1];
            always_comb begin
               data_d = '0;
               for (int w = 0; w < WORDS; w++) begin
                  data_d[w*DATA_WIDTH +: DATA_WIDTH] =
                     g_st[j-1].data_q[(w*RADIX + int'(digit))*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end

         always_ff @(posedge clk or negedge async_reset_n) begin
            if (!async_reset_n) begin
               data_q <= '0;
            end else if (load[j] && pred_vld) begin
               data_q <= data_d;
            end
         end
      end
   endgenerate

   assign bus.ready_o     = load[0];
   assign bus.valid_o     = vld_q[LEVELS];
   assign bus.sel_o       = sel_q[LEVELS];
   assign bus.tag_o       = tag_q[LEVELS];
   assign bus.output_word = g_st[LEVELS].data_q;
endmodule

// File: tb/tb_pipe_mux_tree.sv
// Directed bench for pipe_mux_tree: default 16:1 radix-4, 10:1 radix-4 and
// 8:1 radix-2 single-bit instances sharing one clock and reset.
module tb_pipe_mux_tree;
   logic clk = 1'b0;
   logic rst_n;
   int   tests_run    = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   pipe_mux_tree_if #(.NUM_INPUTS(16), .DATA_WIDTH(16), .TAG_WIDTH(4)) ifa ();
   pipe_mux_tree_if #(.NUM_INPUTS(10), .DATA_WIDTH(16), .TAG_WIDTH(4)) ifb ();
   pipe_mux_tree_if #(.NUM_INPUTS(8),  .DATA_WIDTH(1),  .TAG_WIDTH(4)) ifc ();

   pipe_mux_tree #(.NUM_INPUTS(16), .DATA_WIDTH(16), .RADIX(4), .TAG_WIDTH(4)) u_a (
      .clk(clk), .async_reset_n(rst_n), .bus(ifa));
   pipe_mux_tree #(.NUM_INPUTS(10), .DATA_WIDTH(16), .RADIX(4), .TAG_WIDTH(4)) u_b (
      .clk(clk), .async_reset_n(rst_n), .bus(ifb));
   pipe_mux_tree #(.NUM_INPUTS(8), .DATA_WIDTH(1), .RADIX(2), .TAG_WIDTH(4)) u_c (
      .clk(clk), .async_reset_n(rst_n), .bus(ifc));

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (ifa.valid_o !== 1'b0) begin
         tests_failed++; $display("FAIL reset_valid_o: got %b want 0", ifa.valid_o);
      end
      tests_run++;
      if (ifa.output_word !== 16'h0000) begin
         tests_failed++; $display("FAIL reset_output_word: got %h want 0000", ifa.output_word);
      end
      tests_run++;
      if (ifa.sel_o !== 4'd0 || ifa.tag_o !== 4'd0) begin
         tests_failed++; $display("FAIL reset_sel_tag: got sel %0d tag %0d want 0 0", ifa.sel_o, ifa.tag_o);
      end
      tests_run++;
      if (ifb.valid_o !== 1'b0 || ifc.valid_o !== 1'b0) begin
         tests_failed++; $display("FAIL reset_valid_bc: got %b %b want 0 0", ifb.valid_o, ifc.valid_o);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (ifa.ready_o !== 1'b1 || ifb.ready_o !== 1'b1 || ifc.ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready_o: got %b %b %b want 1 1 1", ifa.ready_o, ifb.ready_o, ifc.ready_o);
      end
   endtask

   task automatic test_sweep();
      bit exp_v;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         ifa.valid_i = (c < 16);
         ifa.sel     = 4'(c);
         ifa.tag_i   = 4'(c);
         ifa.ready_i = 1'b1;
         @(negedge clk);
         if (c < 16) begin
            tests_run++;
            if (ifa.ready_o !== 1'b1) begin
               tests_failed++; $display("FAIL sweep_ready c=%0d: got %b want 1", c, ifa.ready_o);
            end
         end
         exp_v = (c >= 3 && c < 19);
         tests_run++;
         if (ifa.valid_o !== exp_v) begin
            tests_failed++; $display("FAIL sweep_valid c=%0d: got %b want %b", c, ifa.valid_o, exp_v);
         end
         if (exp_v) begin
            tests_run++;
            if (ifa.output_word !== 16'(16'hA000 + c - 3) || ifa.sel_o !== 4'(c - 3) ||
                ifa.tag_o !== 4'(c - 3)) begin
               tests_failed++;
               $display("FAIL sweep_word c=%0d: got %h sel %0d tag %0d want %h sel %0d", c,
                        ifa.output_word, ifa.sel_o, ifa.tag_o, 16'(16'hA000 + c - 3), c - 3);
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         ifb.valid_i = (c < 2);
         ifb.sel     = (c == 0) ? 4'd9 : 4'd12;
         ifb.tag_i   = 4'(c + 1);
         ifb.ready_i = 1'b1;
         @(negedge clk);
         if (c == 3) begin
            tests_run++;
            if (ifb.valid_o !== 1'b1 || ifb.output_word !== 16'hB009 || ifb.sel_o !== 4'd9) begin
               tests_failed++;
               $display("FAIL oor_sel9: got v %b word %h sel %0d want 1 b009 9",
                        ifb.valid_o, ifb.output_word, ifb.sel_o);
            end
         end
         if (c == 4) begin
            tests_run++;
            if (ifb.valid_o !== 1'b1 || ifb.output_word !== 16'h0000 || ifb.sel_o !== 4'd12 ||
                ifb.tag_o !== 4'd2) begin
               tests_failed++;
               $display("FAIL oor_sel12: got v %b word %h sel %0d tag %0d want 1 0000 12 2",
                        ifb.valid_o, ifb.output_word, ifb.sel_o, ifb.tag_o);
            end
         end
         if (c == 5) begin
            tests_run++;
            if (ifb.valid_o !== 1'b0) begin
               tests_failed++; $display("FAIL oor_drain: got valid %b want 0", ifb.valid_o);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int n_in  = 0;
      int n_out = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         ifa.ready_i = (c >= 6);
         ifa.valid_i = (n_in < 6);
         ifa.sel     = 4'(n_in);
         ifa.tag_i   = 4'(n_in + 1);
         @(negedge clk);
         if (c == 3 || c == 5) begin
            tests_run++;
            if (ifa.valid_o !== 1'b1 || ifa.output_word !== 16'hA000 || ifa.tag_o !== 4'd1) begin
               tests_failed++;
               $display("FAIL bp_stall_hold c=%0d: got v %b word %h tag %0d want 1 a000 1",
                        c, ifa.valid_o, ifa.output_word, ifa.tag_o);
            end
         end
         if (c == 5) begin
            tests_run++;
            if (n_in !== 3 || ifa.ready_o !== 1'b0) begin
               tests_failed++;
               $display("FAIL bp_absorb: got accepted %0d ready %b want 3 0", n_in, ifa.ready_o);
            end
         end
         if (ifa.valid_i && ifa.ready_o) n_in++;
         if (ifa.valid_o && ifa.ready_i) begin
            tests_run++;
            if (n_out >= 6) begin
               tests_failed++; $display("FAIL bp_extra: got beat tag %0d want none", ifa.tag_o);
            end else if (ifa.output_word !== 16'(16'hA000 + n_out) || ifa.tag_o !== 4'(n_out + 1)) begin
               tests_failed++;
               $display("FAIL bp_order n=%0d: got %h tag %0d want %h tag %0d", n_out,
                        ifa.output_word, ifa.tag_o, 16'(16'hA000 + n_out), n_out + 1);
            end
            n_out++;
         end
      end
      tests_run++;
      if (n_out !== 6 || n_in !== 6) begin
         tests_failed++; $display("FAIL bp_count: got in %0d out %0d want 6 6", n_in, n_out);
      end
   endtask

   task automatic test_bubbles();
      bit         vpat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [3:0] tpat [5] = '{4'd1, 4'd0, 4'd2, 4'd3, 4'd0};
      int idx   = 0;
      int n_out = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         ifa.ready_i = (c % 2 == 1);
         ifa.valid_i = (idx < 5) ? vpat[idx] : 1'b0;
         ifa.tag_i   = (idx < 5) ? tpat[idx] : 4'd0;
         ifa.sel     = ifa.tag_i + 4'd4;
         @(negedge clk);
         if (idx < 5 && (!vpat[idx] || ifa.ready_o)) idx++;
         if (ifa.valid_o && ifa.ready_i) begin
            tests_run++;
            if (n_out >= 3) begin
               tests_failed++; $display("FAIL bubble_dup: got extra tag %0d want none", ifa.tag_o);
            end else if (ifa.tag_o !== 4'(n_out + 1) || ifa.output_word !== 16'(16'hA005 + n_out)) begin
               tests_failed++;
               $display("FAIL bubble_order n=%0d: got tag %0d word %h want tag %0d word %h", n_out,
                        ifa.tag_o, ifa.output_word, n_out + 1, 16'(16'hA005 + n_out));
            end
            n_out++;
         end
      end
      tests_run++;
      if (n_out !== 3) begin
         tests_failed++; $display("FAIL bubble_count: got %0d want 3", n_out);
      end
   endtask

   task automatic test_reset_midflight();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         ifa.ready_i = 1'b0;
         ifa.valid_i = (c < 2);
         ifa.sel     = 4'(c + 2);
         ifa.tag_i   = 4'(c + 5);
      end
      @(posedge clk); #1;
      tests_run++;
      if (ifa.valid_o !== 1'b1 || ifa.tag_o !== 4'd5) begin
         tests_failed++; $display("FAIL mid_preload: got v %b tag %0d want 1 5", ifa.valid_o, ifa.tag_o);
      end
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (ifa.valid_o !== 1'b0 || ifa.output_word !== 16'h0000 || ifa.sel_o !== 4'd0) begin
         tests_failed++;
         $display("FAIL mid_async_clear: got v %b word %h sel %0d want 0 0000 0",
                  ifa.valid_o, ifa.output_word, ifa.sel_o);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (ifa.ready_o !== 1'b1) begin
         tests_failed++; $display("FAIL mid_ready: got %b want 1", ifa.ready_o);
      end
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         ifa.ready_i = 1'b1;
         @(negedge clk);
         tests_run++;
         if (ifa.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL mid_stale c=%0d: got valid %b want 0", c, ifa.valid_o);
         end
      end
   endtask

   task automatic test_radix2();
      bit exp_bits [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      bit exp_v;
      for (int c = 0; c < 13; c++) begin
         @(posedge clk); #1;
         ifc.valid_i = (c < 8);
         ifc.sel     = 3'(c);
         ifc.tag_i   = 4'(c);
         ifc.ready_i = 1'b1;
         @(negedge clk);
         exp_v = (c >= 4 && c < 12);
         tests_run++;
         if (ifc.valid_o !== exp_v) begin
            tests_failed++; $display("FAIL r2_valid c=%0d: got %b want %b", c, ifc.valid_o, exp_v);
         end
         if (exp_v) begin
            tests_run++;
            if (ifc.output_word !== exp_bits[c-4] || ifc.sel_o !== 3'(c - 4)) begin
               tests_failed++;
               $display("FAIL r2_bit c=%0d: got %b sel %0d want %b sel %0d", c,
                        ifc.output_word, ifc.sel_o, exp_bits[c-4], c - 4);
            end
         end
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      ifa.valid_i    = 1'b0; ifa.ready_i = 1'b0; ifa.sel = '0; ifa.tag_i = '0;
      ifb.valid_i    = 1'b0; ifb.ready_i = 1'b0; ifb.sel = '0; ifb.tag_i = '0;
      ifc.valid_i    = 1'b0; ifc.ready_i = 1'b0; ifc.sel = '0; ifc.tag_i = '0;
      ifa.input_word = '0;
      ifb.input_word = '0;
      for (int k = 0; k < 16; k++) ifa.input_word[k*16 +: 16] = 16'(16'hA000 + k);
      for (int k = 0; k < 10; k++) ifb.input_word[k*16 +: 16] = 16'(16'hB000 + k);
      ifc.input_word = 8'b1011_0010;

      test_reset();
      test_sweep();
      test_out_of_range();
      test_backpressure();
      test_bubbles();
      test_reset_midflight();
      test_radix2();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion want finish before 100000");
      $fatal(1);
   end
endmodule
